// File: rtl/axil_result_writer.sv
// AXI4-Lite master that writes streamed 32-bit result words to consecutive
// slave registers, one transaction in flight, with sticky error reporting.
module axil_result_writer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          NUM_REGS       = 4,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [31:0]           S_DATA,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [3:0]            word_idx,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err_resp,
    output logic                  err_timeout,
    input  logic                  err_clear
);

    typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

    localparam logic [3:0]  LAST_IDX    = 4'(NUM_REGS - 1);
    localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT_CYCLES);

    state_t                r_state;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_bready;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_err_resp;
    logic                  r_err_timeout;
    logic [3:0]            r_word_idx;
    logic [15:0]           r_timer;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]           r_wdata;

    logic w_aw_fin;
    logic w_w_fin;
    logic w_in_flight;
    logic w_timer_hit;

    // A channel counts as finished if it completed earlier or handshakes now.
    assign w_aw_fin    = r_aw_done || (r_awvalid && M_AXI_AWREADY);
    assign w_w_fin     = r_w_done  || (r_wvalid  && M_AXI_WREADY);
    assign w_in_flight = (r_state != IDLE);
    assign w_timer_hit = w_in_flight && (r_timer == TIMEOUT_MAX - 16'd1);

    assign S_READY       = !r_busy;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign word_idx      = r_word_idx;
    assign frame_done    = r_frame_done;
    assign busy          = r_busy;
    assign err_resp      = r_err_resp;
    assign err_timeout   = r_err_timeout;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state       <= IDLE;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_bready      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_resp    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_word_idx    <= 4'd0;
            r_timer       <= 16'd0;
            r_awaddr      <= '0;
            r_wdata       <= 32'd0;
        end else begin
            r_frame_done <= 1'b0;

            // Clear first so that a same-cycle set below takes priority.
            if (err_clear) begin
                r_err_resp    <= 1'b0;
                r_err_timeout <= 1'b0;
            end

            if (w_in_flight && (r_timer != TIMEOUT_MAX)) begin
                r_timer <= r_timer + 16'd1;
            end
            if (w_timer_hit) begin
                r_err_timeout <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_timer <= 16'd0;
                    if (S_VALID) begin
                        r_wdata   <= S_DATA;
                        r_awaddr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({r_word_idx, 2'b00});
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (r_awvalid && M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    // Error responses still advance the index; there is no retry.
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00) begin
                            r_err_resp <= 1'b1;
                        end
                        if (r_word_idx == LAST_IDX) begin
                            r_word_idx   <= 4'd0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_word_idx <= r_word_idx + 4'd1;
                        end
                        r_bready <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_result_writer.sv
// Self-checking bench for axil_result_writer: a configurable-latency slave
// model plus a word-level reference model of addressing, framing and errors.
module tb_axil_result_writer;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          NREGS = 4;
    localparam int          TMO   = 16;

    logic        ACLK;
    logic        ARESETN;
    logic        S_VALID;
    logic        S_READY;
    logic [31:0] S_DATA;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [3:0]  word_idx;
    logic        frame_done;
    logic        busy;
    logic        err_resp;
    logic        err_timeout;
    logic        err_clear;

    axil_result_writer #(
        .BASE_ADDR      (BASE),
        .NUM_REGS       (NREGS),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_VALID       (S_VALID),
        .S_READY       (S_READY),
        .S_DATA        (S_DATA),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .word_idx      (word_idx),
        .frame_done    (frame_done),
        .busy          (busy),
        .err_resp      (err_resp),
        .err_timeout   (err_timeout),
        .err_clear     (err_clear)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Slave configuration, written only by the test sequence.
    int         aw_delay;
    int         w_delay;
    int         b_delay;
    bit         withhold_b;
    logic [1:0] bresp_plan [0:255];

    // Slave observations, written only by the slave model.
    int          b_count;
    int          awv_cycles;
    int          wv_cycles;
    int          busy_cycles;
    int          fd_cycles;
    int          unstable_cnt;
    int          sready_busy;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    logic [31:0] mem [0:NREGS-1];

    // Reference model state.
    int total;
    int bad;
    int model_idx;
    bit model_err;

    initial begin : slave_model
        int          aw_wait;
        int          w_wait;
        int          b_wait;
        bit          have_a;
        bit          have_w;
        bit          aw_hs;
        bit          w_hs;
        bit          b_hs;
        bit          prev_awv;
        bit          prev_wv;
        logic [31:0] cur_a;
        logic [31:0] cur_w;
        logic [31:0] prev_a;
        logic [31:0] prev_w;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        b_count = 0; awv_cycles = 0; wv_cycles = 0; busy_cycles = 0;
        fd_cycles = 0; unstable_cnt = 0; sready_busy = 0;
        last_addr = '0; last_data = '0;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        have_a = 0; have_w = 0; prev_awv = 0; prev_wv = 0;
        cur_a = '0; cur_w = '0; prev_a = '0; prev_w = '0;
        for (int i = 0; i < NREGS; i++) mem[i] = '0;
        forever begin
            @(posedge ACLK);
            aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
            w_hs  = M_AXI_WVALID && M_AXI_WREADY;
            b_hs  = M_AXI_BVALID && M_AXI_BREADY;
            if (M_AXI_AWVALID) awv_cycles++;
            if (M_AXI_WVALID) wv_cycles++;
            if (busy) busy_cycles++;
            if (busy && S_READY) sready_busy++;
            if (frame_done) fd_cycles++;
            if (M_AXI_AWVALID && prev_awv && (M_AXI_AWADDR != prev_a)) unstable_cnt++;
            if (M_AXI_WVALID && prev_wv && (M_AXI_WDATA != prev_w)) unstable_cnt++;
            prev_awv = M_AXI_AWVALID; prev_a = M_AXI_AWADDR;
            prev_wv  = M_AXI_WVALID;  prev_w = M_AXI_WDATA;
            if (!ARESETN) begin
                have_a = 0; have_w = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end else begin
                if (aw_hs) begin have_a = 1; cur_a = M_AXI_AWADDR; end
                if (w_hs) begin have_w = 1; cur_w = M_AXI_WDATA; end
                if (b_hs) begin
                    last_addr = cur_a;
                    last_data = cur_w;
                    if (M_AXI_BRESP == 2'b00 && ((cur_a - BASE) >> 2) < NREGS)
                        mem[(cur_a - BASE) >> 2] = cur_w;
                    b_count++;
                    have_a = 0; have_w = 0; b_wait = 0;
                end
            end
            #1;
            if (!ARESETN) begin
                M_AXI_AWREADY = 1'b0;
                M_AXI_WREADY  = 1'b0;
                M_AXI_BVALID  = 1'b0;
                M_AXI_BRESP   = 2'b00;
            end else begin
                if (M_AXI_AWVALID) begin
                    M_AXI_AWREADY = (aw_wait >= aw_delay);
                    aw_wait++;
                end else begin
                    M_AXI_AWREADY = 1'b0;
                    aw_wait = 0;
                end
                if (M_AXI_WVALID) begin
                    M_AXI_WREADY = (w_wait >= w_delay);
                    w_wait++;
                end else begin
                    M_AXI_WREADY = 1'b0;
                    w_wait = 0;
                end
                if (have_a && have_w && !withhold_b) begin
                    if (b_wait >= b_delay) begin
                        M_AXI_BVALID = 1'b1;
                        M_AXI_BRESP  = bresp_plan[b_count % 256];
                    end else begin
                        M_AXI_BVALID = 1'b0;
                    end
                    b_wait++;
                end else begin
                    M_AXI_BVALID = 1'b0;
                    M_AXI_BRESP  = 2'b00;
                end
            end
        end
    end

    task automatic do_reset();
        ARESETN = 1'b0;
        S_VALID = 1'b0;
        S_DATA = 32'd0;
        err_clear = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        model_idx = 0;
        model_err = 0;
    endtask

    task automatic start_word(input logic [31:0] d, output bit ok);
        int n = 0;
        ok = 1;
        while (!S_READY && n < 100) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        if (!S_READY) begin
            total++; bad++; ok = 0;
            $display("FAIL start_wait s_ready got=%b want=1 after %0d cycles", S_READY, n);
            return;
        end
        S_VALID = 1'b1;
        S_DATA = d;
        @(posedge ACLK);
        #1;
        S_VALID = 1'b0;
        S_DATA = $urandom;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        ok = 1;
        while (busy && n < 100) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; ok = 0;
            $display("FAIL done_wait busy got=%b want=0 after %0d cycles", busy, n);
        end
        @(posedge ACLK);
        #1;
    endtask

    // One word through the model: address from the running index, in-flight
    // length from the slave latencies, frame pulse on wrap, sticky error.
    task automatic run_word(input logic [31:0] d, input logic [1:0] resp,
                            input int awd, input int wd, input int bd, input string tag);
        int          b0, bc0, fd0, exp_busy, exp_fd;
        logic [31:0] exp_addr;
        bit          ok;
        aw_delay = awd; w_delay = wd; b_delay = bd; withhold_b = 0;
        b0 = b_count; bc0 = busy_cycles; fd0 = fd_cycles;
        bresp_plan[b0 % 256] = resp;
        exp_addr = BASE + 32'(4 * model_idx);
        exp_busy = ((awd > wd) ? awd : wd) + bd + 2;
        start_word(d, ok);
        if (!ok) return;
        wait_done(ok);
        if (resp != 2'b00) model_err = 1;
        model_idx = (model_idx + 1) % NREGS;
        exp_fd = (model_idx == 0) ? 1 : 0;
        total++;
        if (b_count !== b0 + 1) begin bad++; $display("FAIL %s b_count got=%0d want=%0d", tag, b_count, b0 + 1); end
        total++;
        if (last_addr !== exp_addr) begin bad++; $display("FAIL %s awaddr got=%h want=%h", tag, last_addr, exp_addr); end
        total++;
        if (last_data !== d) begin bad++; $display("FAIL %s wdata got=%h want=%h", tag, last_data, d); end
        total++;
        if (busy_cycles - bc0 !== exp_busy) begin bad++; $display("FAIL %s busy_len got=%0d want=%0d", tag, busy_cycles - bc0, exp_busy); end
        total++;
        if (fd_cycles - fd0 !== exp_fd) begin bad++; $display("FAIL %s frame_done_cycles got=%0d want=%0d", tag, fd_cycles - fd0, exp_fd); end
        total++;
        if (word_idx !== 4'(model_idx)) begin bad++; $display("FAIL %s word_idx got=%0d want=%0d", tag, word_idx, model_idx); end
        total++;
        if (err_resp !== model_err) begin bad++; $display("FAIL %s err_resp got=%b want=%b", tag, err_resp, model_err); end
        total++;
        if (err_timeout !== 1'b0) begin bad++; $display("FAIL %s err_timeout got=%b want=0", tag, err_timeout); end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (S_READY !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", S_READY); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (M_AXI_AWVALID !== 1'b0) begin bad++; $display("FAIL reset_awvalid got=%b want=0", M_AXI_AWVALID); end
        total++; if (M_AXI_WVALID !== 1'b0) begin bad++; $display("FAIL reset_wvalid got=%b want=0", M_AXI_WVALID); end
        total++; if (M_AXI_BREADY !== 1'b0) begin bad++; $display("FAIL reset_bready got=%b want=0", M_AXI_BREADY); end
        total++; if (word_idx !== 4'd0) begin bad++; $display("FAIL reset_word_idx got=%0d want=0", word_idx); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (err_resp !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL reset_errors got=%b%b want=00", err_resp, err_timeout); end
        total++; if (M_AXI_AWADDR !== 32'd0 || M_AXI_WDATA !== 32'd0) begin bad++; $display("FAIL reset_addr_data got=%h/%h want=0/0", M_AXI_AWADDR, M_AXI_WDATA); end
        total++; if (M_AXI_AWPROT !== 3'b000 || M_AXI_WSTRB !== 4'hF) begin bad++; $display("FAIL reset_prot_strb got=%b/%h want=000/f", M_AXI_AWPROT, M_AXI_WSTRB); end
    endtask

    task automatic test_zero_wait_frame();
        for (int i = 1; i <= 4; i++) run_word(32'(i), 2'b00, 0, 0, 0, "zero_wait");
        for (int i = 0; i < NREGS; i++) begin
            total++;
            if (mem[i] !== 32'(i + 1)) begin bad++; $display("FAIL readback_reg%0d got=%h want=%h", i, mem[i], i + 1); end
        end
    endtask

    task automatic test_aw_delay();
        int a0 = awv_cycles, w0 = wv_cycles, u0 = unstable_cnt, s0 = sready_busy;
        run_word(32'hDEAD_0001, 2'b00, 3, 0, 0, "aw_delay");
        total++; if (awv_cycles - a0 !== 4) begin bad++; $display("FAIL aw_delay_awvalid_len got=%0d want=4", awv_cycles - a0); end
        total++; if (wv_cycles - w0 !== 1) begin bad++; $display("FAIL aw_delay_wvalid_len got=%0d want=1", wv_cycles - w0); end
        total++; if (unstable_cnt - u0 !== 0) begin bad++; $display("FAIL aw_delay_stability got=%0d changes want=0", unstable_cnt - u0); end
        total++; if (sready_busy - s0 !== 0) begin bad++; $display("FAIL aw_delay_s_ready_busy got=%0d cycles want=0", sready_busy - s0); end
    endtask

    task automatic test_slverr();
        do_reset();
        run_word(32'd10, 2'b00, 0, 0, 0, "slverr_w0");
        run_word(32'd20, 2'b00, 0, 0, 0, "slverr_w1");
        run_word(32'd30, 2'b10, 0, 0, 0, "slverr_w2");
        run_word(32'd40, 2'b00, 0, 0, 0, "slverr_w3");
    endtask

    task automatic test_err_clear_same_cycle();
        bit ok;
        int n = 0;
        err_clear = 1'b1;
        @(posedge ACLK);
        #1;
        err_clear = 1'b0;
        model_err = 0;
        total++; if (err_resp !== 1'b0) begin bad++; $display("FAIL clear_idle err_resp got=%b want=0", err_resp); end
        aw_delay = 0; w_delay = 0; b_delay = 0; withhold_b = 0;
        bresp_plan[b_count % 256] = 2'b11;
        start_word(32'h0BAD_F00D, ok);
        if (!ok) return;
        do begin
            @(negedge ACLK);
            n++;
        end while (!(M_AXI_BVALID && M_AXI_BREADY) && n < 20);
        total++; if (!(M_AXI_BVALID && M_AXI_BREADY)) begin bad++; $display("FAIL clear_race b_handshake got=0 want=1"); end
        err_clear = 1'b1;
        @(posedge ACLK);
        #1;
        err_clear = 1'b0;
        model_err = 1;
        total++; if (err_resp !== model_err) begin bad++; $display("FAIL clear_race err_resp got=%b want=%b", err_resp, model_err); end
        wait_done(ok);
        model_idx = (model_idx + 1) % NREGS;
        total++; if (word_idx !== 4'(model_idx)) begin bad++; $display("FAIL clear_race word_idx got=%0d want=%0d", word_idx, model_idx); end
        err_clear = 1'b1;
        @(posedge ACLK);
        #1;
        err_clear = 1'b0;
        model_err = 0;
        total++; if (err_resp !== 1'b0) begin bad++; $display("FAIL clear_after err_resp got=%b want=0", err_resp); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; withhold_b = 1;
        bresp_plan[b_count % 256] = 2'b00;
        start_word(32'h7777_0000, ok);
        if (!ok) return;
        while (!err_timeout && n < 3 * TMO) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        total++; if (n !== TMO) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", n, TMO); end
        repeat (4) @(posedge ACLK);
        #1;
        total++; if (busy !== 1'b1 || S_READY !== 1'b0) begin bad++; $display("FAIL timeout_waiting busy/s_ready got=%b/%b want=1/0", busy, S_READY); end
        withhold_b = 0;
        wait_done(ok);
        model_idx = (model_idx + 1) % NREGS;
        total++; if (S_READY !== 1'b1) begin bad++; $display("FAIL timeout_release s_ready got=%b want=1", S_READY); end
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", err_timeout); end
        err_clear = 1'b1;
        @(posedge ACLK);
        #1;
        err_clear = 1'b0;
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", err_timeout); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        run_word(32'h1111_1111, 2'b00, 0, 0, 0, "pre_reset");
        aw_delay = 3; w_delay = 0; b_delay = 0; withhold_b = 0;
        bresp_plan[b_count % 256] = 2'b00;
        start_word(32'h2222_2222, ok);
        if (!ok) return;
        @(posedge ACLK);
        #2;
        total++; if (M_AXI_AWVALID !== 1'b1) begin bad++; $display("FAIL midreset_before awvalid got=%b want=1", M_AXI_AWVALID); end
        ARESETN = 1'b0;
        #1;
        total++; if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0) begin bad++; $display("FAIL midreset_valids got=%b/%b want=0/0", M_AXI_AWVALID, M_AXI_WVALID); end
        total++; if (busy !== 1'b0 || word_idx !== 4'd0) begin bad++; $display("FAIL midreset_state busy/idx got=%b/%0d want=0/0", busy, word_idx); end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        model_idx = 0;
        model_err = 0;
        run_word(32'h3333_3333, 2'b00, 0, 0, 0, "post_reset");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            logic [1:0] resp;
            if ($urandom_range(0, 5) == 0) begin
                err_clear = 1'b1;
                @(posedge ACLK);
                #1;
                err_clear = 1'b0;
                model_err = 0;
                total++; if (err_resp !== 1'b0) begin bad++; $display("FAIL rand_clear err_resp got=%b want=0", err_resp); end
            end
            resp = 2'b00;
            if ($urandom_range(0, 3) == 0) resp = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
            run_word($urandom, resp, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 4)), "random");
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; withhold_b = 0;
        for (int i = 0; i < 256; i++) bresp_plan[i] = 2'b00;
        test_reset();
        test_zero_wait_frame();
        test_aw_delay();
        test_slverr();
        test_err_clear_same_cycle();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
